// File: rtl/writeback_arbiter_if.sv
// Writeback bus bundle: ALU/LSU result handshakes, issue/flush, register-file
// write and scoreboard. master = producers/decode side, slave = arbiter.
interface writeback_arbiter_if #(
  parameter int xlen = 32
);
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [xlen-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [xlen-1:0] lsu_data;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            flush;
  logic            w_valid;
  logic [4:0]      w_ad;
  logic [xlen-1:0] w_data;
  logic [31:0]     busy;

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    output issue_valid, issue_rd, flush,
    input  w_valid, w_ad, w_data, busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    input  issue_valid, issue_rd, flush,
    output w_valid, w_ad, w_data, busy
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: LSU-priority grant with ALU anti-starvation, registered
// register-file write port and 32-entry pending-write scoreboard.
module writeback_arbiter #(
  parameter int xlen         = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                clk,
  input  logic                rst,
  writeback_arbiter_if.slave  bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
  logic            w_valid_q, w_valid_d;
  logic [4:0]      w_ad_q, w_ad_d;
  logic [xlen-1:0] w_data_q, w_data_d;
  logic [31:0]     busy_q, busy_d;

  logic            starve_hit;
  logic            alu_ready, lsu_ready;
  logic            alu_xfer, lsu_xfer, xfer;
  logic [4:0]      win_rd;
  logic [xlen-1:0] win_data;

  // Grant depends only on valids and the counter, never on rd/data.
  assign starve_hit = (starve_cnt_q == CW'(STARVE_LIMIT));
  assign alu_ready  = !bus.lsu_valid || starve_hit;
  assign lsu_ready  = !(bus.alu_valid && starve_hit);
  assign alu_xfer   = bus.alu_valid && alu_ready;
  assign lsu_xfer   = bus.lsu_valid && lsu_ready;
  assign xfer       = alu_xfer || lsu_xfer;
  assign win_rd     = lsu_xfer ? bus.lsu_rd   : bus.alu_rd;
  assign win_data   = lsu_xfer ? bus.lsu_data : bus.alu_data;

  always_comb begin
    starve_cnt_d = '0;
    if (bus.alu_valid && !alu_ready && (starve_cnt_q != CW'(STARVE_LIMIT)))
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  always_comb begin
    w_valid_d = 1'b0;
    w_ad_d    = w_ad_q;
    w_data_d  = w_data_q;
    if (xfer) begin
      w_valid_d = (win_rd != 5'd0);
      w_ad_d    = win_rd;
      w_data_d  = win_data;
    end
  end

  // Issue set is applied last so a newer producer beats both retire and flush.
  always_comb begin
    busy_d = busy_q;
    if (bus.flush) busy_d = '0;
    if (xfer) busy_d[win_rd] = 1'b0;
    if (bus.issue_valid) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
      w_valid_q    <= 1'b0;
      w_ad_q       <= '0;
      w_data_q     <= '0;
      busy_q       <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      w_valid_q    <= w_valid_d;
      w_ad_q       <= w_ad_d;
      w_data_q     <= w_data_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.alu_ready = alu_ready;
  assign bus.lsu_ready = lsu_ready;
  assign bus.w_valid   = w_valid_q;
  assign bus.w_ad      = w_ad_q;
  assign bus.w_data    = w_data_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed plus randomized bench for writeback_arbiter against a
// transaction-level reference model.
module tb_writeback_arbiter;
  localparam int XLEN = 32;
  localparam int LIM  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  writeback_arbiter_if #(.xlen(XLEN)) b();

  writeback_arbiter #(.xlen(XLEN), .STARVE_LIMIT(LIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  int vectors = 0;
  int errs    = 0;

  // Reference model state: consecutive ALU losses, pending set, last write.
  int          m_loss;
  bit [31:0]   m_busy;
  bit          m_wv;
  bit [4:0]    m_wad;
  bit [31:0]   m_wdata;
  bit          g_ax, g_lx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_loss = 0; m_busy = '0; m_wv = 0; m_wad = '0; m_wdata = '0;
  endtask

  task automatic idle_inputs();
    b.alu_valid = 0; b.alu_rd = '0; b.alu_data = '0;
    b.lsu_valid = 0; b.lsu_rd = '0; b.lsu_data = '0;
    b.issue_valid = 0; b.issue_rd = '0; b.flush = 0;
  endtask

  // One clock: check grant mid-cycle, then outputs just after the edge.
  task automatic cyc();
    bit ar, lr;
    bit [4:0] rd; bit [31:0] d;
    bit [31:0] nb;
    @(negedge clk);
    ar = !b.lsu_valid || (m_loss >= LIM);
    lr = !(b.alu_valid && (m_loss >= LIM));
    chk("alu_ready", b.alu_ready, ar);
    chk("lsu_ready", b.lsu_ready, lr);
    g_ax = b.alu_valid && ar;
    g_lx = b.lsu_valid && lr;
    rd = g_lx ? b.lsu_rd : b.alu_rd;
    d  = g_lx ? b.lsu_data : b.alu_data;
    nb = m_busy;
    if (b.flush) nb = '0;
    if (g_ax || g_lx) nb[rd] = 1'b0;
    if (b.issue_valid && b.issue_rd != 0) nb[b.issue_rd] = 1'b1;
    @(posedge clk); #1;
    m_loss = (b.alu_valid && !g_ax) ? m_loss + 1 : 0;
    m_busy = nb;
    m_wv   = (g_ax || g_lx) && (rd != 0);
    if (g_ax || g_lx) begin m_wad = rd; m_wdata = d; end
    chk("w_valid", b.w_valid, m_wv);
    chk("w_ad",    b.w_ad,    m_wad);
    chk("w_data",  b.w_data,  m_wdata);
    chk("busy",    b.busy,    m_busy);
  endtask

  initial begin
    bit alu_hold, lsu_hold;
    idle_inputs();
    model_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w_valid", b.w_valid, 0);
    chk("rst_w_ad", b.w_ad, 0);
    chk("rst_w_data", b.w_data, 0);
    chk("rst_busy", b.busy, 0);
    chk("rst_alu_ready", b.alu_ready, 1);
    chk("rst_lsu_ready", b.lsu_ready, 1);
    rst = 0;

    // ALU-only transfer
    b.alu_valid = 1; b.alu_rd = 5; b.alu_data = 32'h1234;
    cyc();
    chk("alu_only_wv", b.w_valid, 1);
    chk("alu_only_wad", b.w_ad, 5);
    chk("alu_only_wdata", b.w_data, 32'h1234);
    idle_inputs();
    cyc();

    // Dual-valid starvation pattern: ALU wins every 4th cycle
    b.alu_valid = 1; b.alu_rd = 3; b.alu_data = 32'hA1A1;
    b.lsu_valid = 1; b.lsu_rd = 4; b.lsu_data = 32'hB2B2;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("grant_alu", g_ax, (i % 4) == 3);
      chk("grant_lsu", g_lx, (i % 4) != 3);
    end
    idle_inputs();
    cyc();

    // Transfer to x0
    b.lsu_valid = 1; b.lsu_rd = 0; b.lsu_data = 32'hFFFF;
    cyc();
    chk("x0_handshake", g_lx, 1);
    chk("x0_no_write", b.w_valid, 0);
    chk("x0_busy", b.busy, 0);
    idle_inputs();

    // Issue rd7, retire two cycles later via LSU
    b.issue_valid = 1; b.issue_rd = 7;
    cyc();
    chk("b7_set", b.busy[7], 1);
    idle_inputs();
    cyc();
    chk("b7_hold", b.busy[7], 1);
    b.lsu_valid = 1; b.lsu_rd = 7; b.lsu_data = 32'h77;
    cyc();
    chk("b7_clear", b.busy[7], 0);
    chk("b7_write", b.w_valid, 1);
    idle_inputs();

    // Same-cycle issue and retire of rd9: set wins; then flush
    b.issue_valid = 1; b.issue_rd = 9;
    cyc();
    b.alu_valid = 1; b.alu_rd = 9; b.alu_data = 32'h99;
    cyc();
    chk("b9_set_wins", b.busy[9], 1);
    chk("b9_wad", b.w_ad, 9);
    idle_inputs();
    b.issue_valid = 1; b.issue_rd = 12;
    cyc();
    idle_inputs();
    b.flush = 1;
    cyc();
    chk("flush_busy", b.busy, 0);
    idle_inputs();

    // Asynchronous reset with ALU starved twice and a write in flight
    b.issue_valid = 1; b.issue_rd = 20;
    cyc();
    idle_inputs();
    b.alu_valid = 1; b.alu_rd = 6; b.alu_data = 32'h66;
    b.lsu_valid = 1; b.lsu_rd = 8; b.lsu_data = 32'h88;
    cyc();
    cyc();
    chk("pre_rst_wv", b.w_valid, 1);
    chk("pre_rst_busy20", b.busy[20], 1);
    #2 rst = 1;
    #1;
    chk("arst_w_valid", b.w_valid, 0);
    chk("arst_busy", b.busy, 0);
    chk("arst_w_ad", b.w_ad, 0);
    model_reset();
    idle_inputs();
    @(posedge clk); #1;
    rst = 0;
    cyc();
    chk("post_rst_no_write", b.w_valid, 0);
    b.alu_valid = 1; b.alu_rd = 6; b.alu_data = 32'h66;
    b.lsu_valid = 1; b.lsu_rd = 8; b.lsu_data = 32'h88;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("post_rst_grant", g_ax, i == 3);
    end
    idle_inputs();
    cyc();

    // Randomized traffic; sources hold rd/data while stalled
    alu_hold = 0; lsu_hold = 0;
    for (int n = 0; n < 400; n++) begin
      if (!alu_hold) begin
        b.alu_valid = ($urandom_range(0, 3) != 0);
        b.alu_rd = 5'($urandom_range(0, 31)); b.alu_data = $urandom;
      end
      if (!lsu_hold) begin
        b.lsu_valid = ($urandom_range(0, 2) != 0);
        b.lsu_rd = 5'($urandom_range(0, 31)); b.lsu_data = $urandom;
      end
      b.issue_valid = ($urandom_range(0, 1) != 0);
      b.issue_rd = 5'($urandom_range(0, 31));
      b.flush = ($urandom_range(0, 15) == 0);
      cyc();
      alu_hold = b.alu_valid && !g_ax;
      lsu_hold = b.lsu_valid && !g_lx;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Writeback stage of the CPU pipeline, directly upstream of the register file write port. It arbitrates between the ALU result path and the load/store unit (LSU) result path, giving one accepted result per cycle. It drives a registered write (`w_valid`/`w_ad`/`w_data`) that the register file commits on the following falling clock edge. It also maintains the 32-entry pending-write scoreboard that decode uses to stall on RAW hazards.

## Interface
Parameters:
- `xlen`, 32, data width of results and register file entries
- `STARVE_LIMIT`, 3, consecutive ALU-lost cycles after which the ALU is granted once (≥1)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `alu_valid`  in  1  ALU result available
- `alu_ready`  out  1  ALU result accepted this cycle when high with `alu_valid`
- `alu_rd`  in  5  ALU destination register
- `alu_data`  in  xlen  ALU result
- `lsu_valid`  in  1  load result available
- `lsu_ready`  out  1  load result accepted this cycle when high with `lsu_valid`
- `lsu_rd`  in  5  load destination register
- `lsu_data`  in  xlen  load data
- `issue_valid`  in  1  decode issues an instruction that writes `issue_rd`
- `issue_rd`  in  5  destination of the issuing instruction
- `flush`  in  1  pipeline flush; clears the scoreboard
- `w_valid`  out  1  register file write enable (registered)
- `w_ad`  out  5  register file write address (registered)
- `w_data`  out  xlen  register file write data (registered)
- `busy`  out  32  scoreboard; bit i high = write to xi pending

## Operation
- Handshake: a source transfers on a rising edge where `valid && ready`. Source holds `rd`/`data` stable while `valid && !ready`.
- Grant, combinational from valids and the starvation counter:
  - `starve_hit = (starve_cnt == STARVE_LIMIT)`
  - `alu_ready = !lsu_valid || starve_hit`
  - `lsu_ready = !(alu_valid && starve_hit)`
  - Exactly one source is granted when both are valid. LSU has priority, except when `starve_hit` is set.
- Starvation counter `starve_cnt`, width $clog2(STARVE_LIMIT+1), updated each edge:
  - Increments when `alu_valid && !alu_ready`.
  - Clears to 0 when the ALU transfers or `alu_valid` is low.
  - Never exceeds `STARVE_LIMIT`.
- Output register, updated each edge:
  - On a transfer: `w_ad`/`w_data` take the winner's `rd`/`data`; `w_valid = (rd != 0)`.
  - A transfer to x0 is accepted but produces no write.
  - With no transfer: `w_valid` = 0; `w_ad`/`w_data` hold their previous values.
- Scoreboard, updated each edge, per bit i:
  - Set when `issue_valid && issue_rd == i && i != 0`.
  - Cleared when a transfer with `rd == i` occurs.
  - Set wins over clear in the same cycle (newer producer).
  - `flush` clears all bits; a simultaneous `issue_valid` set still wins.
  - `busy[0]` is always 0.
- Reset-mid-operation: a held or accepted result is discarded, and no write is emitted after `rst` deasserts.

## Timing
- Reset values: `w_valid`=0, `w_ad`=0, `w_data`=0, `busy`=0, `starve_cnt`=0. Hence `alu_ready`=1 and `lsu_ready`=1.
- Latency: a result transferred at edge N appears on `w_*` during cycle N+1. The register file commits it at the falling edge inside cycle N+1.
- `busy[rd]` falls at edge N, i.e. the same edge as the transfer. Decode sees it clear in cycle N+1, when the write lands at mid-cycle.
- Throughput: one transfer per cycle. Sustained dual-valid traffic gives the ALU 1 of every `STARVE_LIMIT+1` cycles.
- The ready outputs have no combinational dependence on `rd`/`data`.

## Test plan
- Reset, then an ALU-only transfer (`alu_rd`=5, data=0x1234) → next cycle `w_valid`=1, `w_ad`=5, `w_data`=0x1234; `alu_ready` stays 1.
- Both valid (ALU rd=3, LSU rd=4), held for 8 cycles, `STARVE_LIMIT`=3 → grant order LSU,LSU,LSU,ALU,LSU,LSU,LSU,ALU. `alu_ready` is high only on cycles 4 and 8.
- Transfer with rd=0, data=0xFFFF → handshake completes, `w_valid`=0 the next cycle, `busy` unchanged.
- `issue_valid` rd=7, then two cycles later an LSU transfer rd=7 → `busy[7]` high for exactly two cycles, low from the cycle `w_valid`=1.
- Same-cycle issue rd=9 and ALU transfer rd=9 while `busy[9]`=1 → `busy[9]` stays 1 and `w_ad`=9 is written next cycle. Then `flush` → `busy`=0.
- Assert `rst` asynchronously with `alu_valid` held and `starve_cnt`=2 → `w_valid`, `busy`, `starve_cnt` go to 0 immediately without waiting for a clock edge, and no write appears after release.
